// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard bus: the pipeline (master) presents the decoded instruction
// and branch resolution; the hazard unit (slave) returns stall/flush and counters.
interface hazard_scoreboard_if #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 32
);
  logic             ID_valid;
  logic [REG_W-1:0] ID_rs1;
  logic [REG_W-1:0] ID_rs2;
  logic             ID_rs1_used;
  logic             ID_rs2_used;
  logic [REG_W-1:0] ID_rd;
  logic             ID_is_load;
  logic             ID_is_long;
  logic             do_flush;
  logic             stall;
  logic             flush;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  modport master (
    output ID_valid, ID_rs1, ID_rs2, ID_rs1_used, ID_rs2_used, ID_rd,
           ID_is_load, ID_is_long, do_flush,
    input  stall, flush, stall_cycles, flush_events
  );

  modport slave (
    input  ID_valid, ID_rs1, ID_rs2, ID_rs1_used, ID_rs2_used, ID_rd,
           ID_is_load, ID_is_long, do_flush,
    output stall, flush, stall_cycles, flush_events
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: per-register latency scoreboard drives stall, a
// stretchable flush kills IF/ID and ID/EX, and saturating counters track both.
module hazard_scoreboard #(
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned LOAD_LAT   = 1,
  parameter int unsigned LONG_LAT   = 3,
  parameter int unsigned FLUSH_HOLD = 1,
  parameter int unsigned CNT_W      = 32
) (
  input logic          clk,
  input logic          reset_n,
  hazard_scoreboard_if.slave hz
);
  localparam int unsigned REG_W   = $clog2(NUM_REGS);
  localparam int unsigned MAX_LAT = (LOAD_LAT > LONG_LAT) ? LOAD_LAT : LONG_LAT;
  localparam int unsigned LAT_W   = $clog2(MAX_LAT + 1);
  localparam int unsigned FC_W    = (FLUSH_HOLD > 1) ? $clog2(FLUSH_HOLD) : 1;

  logic [LAT_W-1:0] pend     [NUM_REGS];
  logic [LAT_W-1:0] pend_nxt [NUM_REGS];
  logic [LAT_W-1:0] dec;
  logic [LAT_W-1:0] lat_c;
  logic [FC_W-1:0]  fcnt;
  logic [REG_W-1:0] last_rd;
  logic             last_valid;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             flush_c;
  logic             stall_c;
  logic             issue_c;
  logic             hit_c;

  // Hazard decision; both outputs are held low while reset is asserted.
  always_comb begin
    flush_c = 1'b0;
    stall_c = 1'b0;
    issue_c = 1'b0;
    hit_c   = (hz.ID_rs1_used && (pend[hz.ID_rs1] != '0)) ||
              (hz.ID_rs2_used && (pend[hz.ID_rs2] != '0));
    if (reset_n) begin
      flush_c = hz.do_flush || (fcnt != '0);
      stall_c = hz.ID_valid && !flush_c && hit_c;
      issue_c = hz.ID_valid && !stall_c && !flush_c;
    end
  end

  // Result latency of the instruction in ID; ALU results forward and never wait.
  always_comb begin
    lat_c = '0;
    if (hz.ID_is_load)      lat_c = LAT_W'(LOAD_LAT);
    else if (hz.ID_is_long) lat_c = LAT_W'(LONG_LAT);
  end

  // Next scoreboard: countdown, WAW keeps the longer wait, flush squashes the killed EX entry.
  always_comb begin
    dec = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      dec         = (pend[r] != '0) ? pend[r] - LAT_W'(1) : '0;
      pend_nxt[r] = dec;
      if (issue_c && (hz.ID_rd == REG_W'(r)) && (r != 0) && (lat_c > dec))
        pend_nxt[r] = lat_c;
      if (hz.do_flush && last_valid && (last_rd == REG_W'(r)))
        pend_nxt[r] = '0;
      if (r == 0)
        pend_nxt[r] = '0;
    end
  end

  // Scoreboard state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) pend[r] <= '0;
    end else begin
      pend <= pend_nxt;
    end
  end

  // Record of the instruction that moved into EX, used for the flush squash.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_valid <= 1'b0;
      last_rd    <= '0;
    end else begin
      last_valid <= issue_c && (hz.ID_rd != '0);
      last_rd    <= hz.ID_rd;
    end
  end

  // Flush stretch counter; a pulse during the hold reloads it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fcnt <= '0;
    end else if (hz.do_flush) begin
      fcnt <= FC_W'(FLUSH_HOLD - 1);
    end else if (fcnt != '0) begin
      fcnt <= fcnt - FC_W'(1);
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_c && (stall_cnt != '1))     stall_cnt <= stall_cnt + CNT_W'(1);
      if (hz.do_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign hz.stall        = stall_c;
  assign hz.flush        = flush_c;
  assign hz.stall_cycles = stall_cnt;
  assign hz.flush_events = flush_cnt;
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard unit for the in-order RISC-V pipeline: it decides stall and flush for the ID stage. A per-register scoreboard with latency countdowns replaces fixed single-cycle load-use detection, so loads and long-latency (multiply/divide) results of any configured depth stall dependents for exactly the right number of cycles. Flushes can be stretched over several cycles, squash the scoreboard entry of the killed EX instruction, and are counted with stalls in saturating performance counters.

## Interface
- NUM_REGS, 32: architectural registers; REG_W = clog2(NUM_REGS).
- LOAD_LAT, 1: cycles after issue before a load result is forwardable (≥1).
- LONG_LAT, 3: same, for long-latency ops (≥1).
- FLUSH_HOLD, 1: cycles flush stays high per do_flush pulse (≥1).
- CNT_W, 32: width of the performance counters.

Clock and reset (already decided): one clock, `clk`; reset `reset_n`, asynchronous, active-low.

- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- ID_valid  in  1  ID holds a real instruction.
- ID_rs1, ID_rs2  in  REG_W  source registers.
- ID_rs1_used, ID_rs2_used  in  1  the source is actually read.
- ID_rd  in  REG_W  destination; 0 means no write.
- ID_is_load  in  1  instruction is a load.
- ID_is_long  in  1  instruction is a long-latency op (exclusive with ID_is_load).
- do_flush  in  1  branch taken or jump resolved; one-cycle pulse.
- stall  out  1  hold PC and IF/ID, inject a bubble into EX.
- flush  out  1  kill the IF/ID and ID/EX contents.
- stall_cycles  out  CNT_W  saturating count of cycles with stall=1.
- flush_events  out  CNT_W  saturating count of do_flush pulses.

## Operation
- Scoreboard: pend[r] is a countdown of width LAT_W = clog2(max(LOAD_LAT,LONG_LAT)+1) for r = 1..NUM_REGS-1. pend[0] is always 0.
- stall = ID_valid && !flush && ((ID_rs1_used && pend[ID_rs1]!=0) || (ID_rs2_used && pend[ID_rs2]!=0)).
- Issue = ID_valid && !stall && !flush.
- Issue latency: LOAD_LAT if ID_is_load, LONG_LAT if ID_is_long, else 0. ALU results are forwarded and never stall.
- Per-register update each edge:
  - If issue to this rd (rd != 0): pend <= max(pend-1 saturating at 0, lat). WAW to a pending register keeps the longer wait.
  - Otherwise, if pend != 0: pend <= pend-1.
- Last-issue record: last_rd and last_valid are loaded on every edge; last_valid = issue && rd!=0.
- Flush squash: on do_flush with last_valid=1, pend[last_rd] <= 0, overriding the decrement. No issue occurs in a flush cycle.
- Flush stretch: flush = do_flush || fcnt!=0. On do_flush, fcnt <= FLUSH_HOLD-1; otherwise it decrements while nonzero. A new do_flush during hold reloads fcnt.
- Priority: flush over stall. stall is forced 0 whenever flush=1.
- Counters: stall_cycles increments on each cycle with stall=1, and flush_events on each do_flush=1. Both saturate at 2^CNT_W-1.

## Timing
- stall and flush are combinational from inputs and registered state in the same cycle. There are no other combinational paths.
- Load issued at edge t with LOAD_LAT=L: a dependent in ID at cycles t+1..t+L stalls, i.e. exactly L bubbles back-to-back. It issues at t+L+1.
- A dependent separated by k ≥ L independent instructions sees no stall.
- FLUSH_HOLD=H: flush is high for cycles t..t+H-1 after a pulse at t.
- Reset (asynchronous, any time including mid-stall or mid-flush):
  - All pend = 0, fcnt = 0, last_valid = 0, counters = 0.
  - While reset_n=0, stall=0 and flush=0 regardless of inputs.
- Counters update one edge after the event.

## Test plan
- Defaults: lw x5 issued, then add x6,x5,x1 in ID -> stall=1 for exactly 1 cycle, then issue; stall_cycles=1.
- LONG_LAT=3: mul x7 followed by a dependent sw using rs2=x7 -> stall high for 3 consecutive cycles; with rs2_used=0 -> no stall.
- Load to x0, then a reader of x0 -> no stall. Dependent placed 2 instructions after a load -> no stall.
- lw x5 issued at t, do_flush at t+1 -> flush=1, stall=0, pend[x5] cleared. At t+2 a reader of x5 does not stall; flush_events=1.
- FLUSH_HOLD=2: pulses at t and t+1 -> flush high t..t+2. mul x3 then lw x3 (WAW) -> pend keeps the longer count.
- reset_n low mid-stall with pend nonzero -> stall and flush go 0 immediately. After release, no stalls and counters read 0.
